// File: rtl/uart_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_seg_pkg
//  Description : Shared types and constants for the UART receive / hex
//                seven-segment display block.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_seg_pkg;

    // Receiver frame states
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Parity modes
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Hex glyphs, segments a..g left to right, 0 = lit
    localparam logic [6:0] HEX_SEG_LUT [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage
`default_nettype wire

// File: rtl/uart_seg_display_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : UART receiver: input synchronizer, frame FSM, parity check
//                and one-cycle result pulses. Last good byte is held on
//                o_data (zero-extended).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_seg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_parity_err
);

    localparam int c_baud_w = $clog2(CLKS_PER_BIT);
    localparam int c_bit_w  = $clog2(DATA_BITS + 1);

    localparam logic [c_baud_w-1:0] c_half_last = c_baud_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_baud_w-1:0] c_full_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_bit_w-1:0]  c_last_bit  = c_bit_w'(DATA_BITS - 1);

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    rx_state_t            r_state;
    rx_state_t            w_state_next;
    logic                 w_tick;
    logic [c_baud_w-1:0]  r_baud;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 w_par_xor;
    logic                 w_par_bad;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;

    // Two-flop synchronizer; line idles high so both stages reset to 1
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (i_reset) r_state <= RX_IDLE;
        else         r_state <= w_state_next;
    end

    // Next state and sample tick; start bit is checked at its midpoint
    always_comb begin
        w_state_next = r_state;
        w_tick       = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (!r_rx_sync) w_state_next = RX_START;
            end
            RX_START: begin
                w_tick = (r_baud == c_half_last);
                if (w_tick) w_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                w_tick = (r_baud == c_full_last);
                if (w_tick && (r_bit_cnt == c_last_bit))
                    w_state_next = (PARITY_MODE != PARITY_NONE) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                w_tick = (r_baud == c_full_last);
                if (w_tick) w_state_next = RX_STOP;
            end
            RX_STOP: begin
                w_tick = (r_baud == c_full_last);
                if (w_tick) w_state_next = RX_IDLE;
            end
            default: w_state_next = RX_IDLE;
        endcase
    end

    // Baud/bit counters, LSB-first shift register and parity bit capture
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
        end else begin
            if ((r_state == RX_IDLE) || w_tick) r_baud <= '0;
            else                                r_baud <= r_baud + 1'b1;

            if (r_state == RX_START)                r_bit_cnt <= '0;
            else if ((r_state == RX_DATA) && w_tick) r_bit_cnt <= r_bit_cnt + 1'b1;

            if ((r_state == RX_DATA) && w_tick)
                r_shift <= {r_rx_sync, r_shift[DATA_BITS-1:1]};

            if ((r_state == RX_PARITY) && w_tick)
                r_par_bit <= r_rx_sync;
        end
    end

    assign w_par_xor = (^r_shift) ^ r_par_bit;
    assign w_par_bad = ((PARITY_MODE == PARITY_EVEN) &&  w_par_xor) ||
                       ((PARITY_MODE == PARITY_ODD)  && !w_par_xor);

    // Stop-bit outcome; a bad stop bit masks a parity error
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            if ((r_state == RX_STOP) && w_tick) begin
                if (!r_rx_sync) begin
                    r_frame_err <= 1'b1;
                end else if (w_par_bad) begin
                    r_parity_err <= 1'b1;
                end else begin
                    r_valid <= 1'b1;
                    r_data  <= 8'(r_shift);
                end
            end
        end
    end

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;

endmodule
`default_nettype wire

// File: rtl/uart_seg_display.sv
`default_nettype none
// ============================================================================
//  Module      : uart_seg_display
//  Description : UART receiver feeding a debug bus, an activity LED and an
//                N-digit multiplexed hex seven-segment display (active-low).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_seg_display
    import uart_seg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_CLKS    = 100000
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_uart_rx,
    output logic [0:7]            o_debug,
    output logic                  o_rx_valid,
    output logic                  o_frame_err,
    output logic                  o_parity_err,
    output logic                  o_uart_led,
    output logic [0:6]            o_segment_enable,
    output logic [0:NUM_DIGITS-1] o_display_enable,
    output logic                  o_dot_enable
);

    localparam int c_buf_w  = 4 * NUM_DIGITS;
    localparam int c_scan_w = $clog2(SCAN_CLKS);
    localparam int c_idx_w  = $clog2(NUM_DIGITS);

    localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_CLKS - 1);
    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(NUM_DIGITS - 1);

    logic [7:0]          w_rx_data;
    logic                w_rx_valid;
    logic                w_frame_err;
    logic                w_parity_err;
    logic [c_buf_w-1:0]  r_buf;
    logic                r_err;
    logic                r_led;
    logic [c_scan_w-1:0] r_scan_cnt;
    logic [c_idx_w-1:0]  r_idx;
    logic [3:0]          w_nibble;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS),
        .PARITY_MODE  (PARITY_MODE)
    ) u_rx_core (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_rx         (i_uart_rx),
        .o_data       (w_rx_data),
        .o_valid      (w_rx_valid),
        .o_frame_err  (w_frame_err),
        .o_parity_err (w_parity_err)
    );

    assign o_debug      = w_rx_data;
    assign o_rx_valid   = w_rx_valid;
    assign o_frame_err  = w_frame_err;
    assign o_parity_err = w_parity_err;
    assign o_uart_led   = r_led;

    // Digit buffer: each good byte enters as two nibbles on the right
    always_ff @(posedge clk) begin
        if (i_reset)         r_buf <= '0;
        else if (w_rx_valid) r_buf <= (r_buf << 8) | c_buf_w'(w_rx_data);
    end

    // Error flag (set by any error pulse, cleared by a good byte) and LED toggle
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_err <= 1'b0;
            r_led <= 1'b0;
        end else if (w_rx_valid) begin
            r_err <= 1'b0;
            r_led <= ~r_led;
        end else if (w_frame_err || w_parity_err) begin
            r_err <= 1'b1;
        end
    end

    // Refresh counter and digit index; index advances on each counter wrap
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == c_scan_last) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Select the active digit's nibble and its low-active enable
    always_comb begin
        w_nibble         = 4'h0;
        o_display_enable = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_nibble            = r_buf[4*i +: 4];
                o_display_enable[i] = 1'b0;
            end
        end
    end

    assign o_segment_enable = HEX_SEG_LUT[w_nibble];
    assign o_dot_enable     = !((r_idx == '0) && r_err);

endmodule
`default_nettype wire

// File: tb/tb_uart_seg_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_seg_display
//  Description : Bench for uart_seg_display. Two instances: 8N1 (index 0)
//                and 8E1 (index 1). Frames are queued with their expected
//                outcome; a negedge monitor compares pulses, debug bus, LED
//                and the scanned display against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_seg_display;

    localparam int CPB  = 16;
    localparam int SCAN = 8;
    localparam int ND   = 4;

    typedef struct {
        int         dut;
        int         kind;   // 0 good, 1 frame error, 2 parity error
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx   [2];
    logic [7:0] dbg  [2];
    logic       vld  [2];
    logic       ferr [2];
    logic       perr [2];
    logic       led  [2];
    logic [6:0] seg  [2];
    logic [3:0] den  [2];
    logic       dot  [2];

    exp_t       expq[$];
    int         checks = 0;
    int         fails  = 0;
    int         n_cyc  = 0;
    bit         rst_q  = 1'b1;
    int         mbuf [2][ND];
    bit         mled [2];
    bit         merr [2];
    logic [7:0] mdbg [2];

    always #5 clk = ~clk;

    uart_seg_display #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0),
        .NUM_DIGITS(ND), .SCAN_CLKS(SCAN)
    ) u_dut_8n1 (
        .clk(clk), .i_reset(rst), .i_uart_rx(rx[0]),
        .o_debug(dbg[0]), .o_rx_valid(vld[0]), .o_frame_err(ferr[0]),
        .o_parity_err(perr[0]), .o_uart_led(led[0]),
        .o_segment_enable(seg[0]), .o_display_enable(den[0]), .o_dot_enable(dot[0])
    );

    uart_seg_display #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1),
        .NUM_DIGITS(ND), .SCAN_CLKS(SCAN)
    ) u_dut_8e1 (
        .clk(clk), .i_reset(rst), .i_uart_rx(rx[1]),
        .o_debug(dbg[1]), .o_rx_valid(vld[1]), .o_frame_err(ferr[1]),
        .o_parity_err(perr[1]), .o_uart_led(led[1]),
        .o_segment_enable(seg[1]), .o_display_enable(den[1]), .o_dot_enable(dot[1])
    );

    function automatic logic [6:0] glyph(int v);
        case (v)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic check(string name, int d, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t: got %0h, expected %0h", name, d, $time, act, req);
        end
    endtask

    // Cycles since reset release, used for the expected scan position
    always @(posedge clk) begin
        rst_q = rst;
        if (rst) n_cyc = 0;
        else     n_cyc = n_cyc + 1;
    end

    // Monitor: compare visible state, then consume any result pulse
    always @(negedge clk) begin : mon
        int         idx;
        int         np;
        int         act_kind;
        bit         popped;
        exp_t       e;
        logic [3:0] en_req;
        for (int d = 0; d < 2; d++) begin
            if (rst_q) begin
                for (int k = 0; k < ND; k++) mbuf[d][k] = 0;
                mled[d] = 1'b0;
                merr[d] = 1'b0;
                mdbg[d] = 8'h00;
            end
            idx    = (n_cyc / SCAN) % ND;
            en_req = ~(4'b1000 >> idx);
            check("display_enable", d, den[d], en_req);
            check("segments", d, seg[d], glyph(mbuf[d][idx]));
            check("dot", d, dot[d], (idx == 0 && merr[d]) ? 0 : 1);
            check("uart_led", d, led[d], mled[d]);

            popped = 1'b0;
            np = int'(vld[d]) + int'(ferr[d]) + int'(perr[d]);
            if (np > 1) begin
                checks++; fails++;
                $display("FAIL pulse_count dut%0d t=%0t: got %0d pulses, expected at most 1", d, $time, np);
            end
            if (np >= 1) begin
                if (expq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_pulse dut%0d t=%0t: got v/f/p=%b%b%b, expected none",
                             d, $time, vld[d], ferr[d], perr[d]);
                end else begin
                    e        = expq.pop_front();
                    popped   = 1'b1;
                    act_kind = vld[d] ? 0 : (ferr[d] ? 1 : 2);
                    check("pulse_dut", d, d, e.dut);
                    check("pulse_kind", d, act_kind, e.kind);
                    if (e.kind == 0) mdbg[d] = e.data;
                end
            end
            check("debug", d, dbg[d], mdbg[d]);

            if (popped) begin
                if (e.kind == 0) begin
                    for (int k = ND - 1; k >= 2; k--) mbuf[d][k] = mbuf[d][k-2];
                    mbuf[d][1] = int'(e.data) / 16;
                    mbuf[d][0] = int'(e.data) % 16;
                    mled[d] = ~mled[d];
                    merr[d] = 1'b0;
                end else begin
                    merr[d] = 1'b1;
                end
            end
        end
    end

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(int d, bit b);
        rx[d] = b;
        idle(CPB);
    endtask

    // Queue the expected outcome from the frame rules, then shift the frame out
    task automatic send_frame(int d, logic [7:0] data, bit par, bit stop);
        exp_t e;
        e.dut  = d;
        e.data = data;
        if (!stop)                                         e.kind = 1;
        else if (d == 1 && (($countones(data) + int'(par)) % 2) != 0) e.kind = 2;
        else                                               e.kind = 0;
        expq.push_back(e);
        drive_bit(d, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d, data[i]);
        if (d == 1) drive_bit(d, par);
        drive_bit(d, stop);
        rx[d] = 1'b1;
        idle(24);
        check("queue_drained", d, expq.size(), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] b;
        int         d;
        bit         stop;
        bit         par;
        rx[0] = 1'b1;
        rx[1] = 1'b1;
        rst   = 1'b1;
        idle(5);
        rst = 1'b0;
        idle(100);

        // Two good bytes on the 8N1 instance
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        send_frame(0, 8'h1F, 1'b0, 1'b1);
        idle(40);

        // Framing error keeps old data, lights the dot; next good byte clears it
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        idle(40);
        send_frame(0, 8'h00, 1'b0, 1'b1);
        idle(40);

        // Even parity: correct, wrong, wrong with bad stop bit
        send_frame(1, 8'h07, 1'b1, 1'b1);
        send_frame(1, 8'h07, 1'b0, 1'b1);
        idle(40);
        send_frame(1, 8'h07, 1'b0, 1'b0);
        idle(40);
        send_frame(1, 8'hC3, 1'b0, 1'b1);

        // Short low glitch is ignored; receiver still works afterwards
        rx[0] = 1'b0;
        idle(4);
        rx[0] = 1'b1;
        idle(200);
        check("glitch_no_pulse", 0, expq.size(), 0);
        send_frame(0, 8'h5A, 1'b0, 1'b1);

        // Reset in the middle of data bit 3
        b = 8'h36;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, b[i]);
        rx[0] = b[3];
        idle(CPB / 2);
        rst = 1'b1;
        idle(2);
        rst   = 1'b0;
        rx[0] = 1'b1;
        idle(60);
        send_frame(0, 8'h9E, 1'b0, 1'b1);
        idle(40);

        // Randomised frames on both instances
        for (int i = 0; i < 24; i++) begin
            d    = int'($urandom_range(0, 1));
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            par  = ($countones(b) % 2 == 1);
            if ($urandom_range(0, 3) == 0) par = ~par;
            send_frame(d, b, (d == 1) ? par : 1'b0, stop);
            idle(int'($urandom_range(0, 40)));
        end

        idle(64);
        check("final_queue_empty", 0, expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
